mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the E stage of the P7 pipeline. Accepts one mult/div/mthi/mtlo operation per issue and sequences its multi-cycle latency with a down-counter FSM. It owns the HI/LO registers, supplies them to the W-stage write-data select, and drives a busy/stall signal so the hazard unit holds any later HI/LO consumer or producer in D. Exception/interrupt flush (`exc_int`) cancels an operation being issued, never one already in flight.

---
 rtl/mdu_ctrl_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 70 +++++++
 rtl/mdu_ctrl.sv | 131 +++++++++++++
 tb/tb_mdu_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide controller.
//   - op codes driven on mdu_ctrl.op. The ten codes need four bits.
//   - FSM state encoding.
//   - default busy latencies.
// Optional feature macro: MDU_MADD_EN, which enables the MADD/MADDU/MSUB/MSUBU codes.
package mdu_ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] md_mult  = 4'd0;
  localparam logic [OP_W-1:0] md_multu = 4'd1;
  localparam logic [OP_W-1:0] md_div   = 4'd2;
  localparam logic [OP_W-1:0] md_divu  = 4'd3;
  localparam logic [OP_W-1:0] md_mthi  = 4'd4;
  localparam logic [OP_W-1:0] md_mtlo  = 4'd5;
  localparam logic [OP_W-1:0] md_madd  = 4'd6;
  localparam logic [OP_W-1:0] md_maddu = 4'd7;
  localparam logic [OP_W-1:0] md_msub  = 4'd8;
  localparam logic [OP_W-1:0] md_msubu = 4'd9;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational 64-bit {hi,lo} result for one HI/LO operation.
// Ports:
//   op_i       operation code
//   a_i, b_i   rs and rt operands
//   hi_i, lo_i current HI/LO, which is the accumulator for MADD/MSUB
//   res_o      {hi,lo} result
// Optional feature macro: MDU_MADD_EN, which decodes MADD/MADDU/MSUB/MSUBU.
// Without the macro, those codes return the current {hi,lo} unchanged.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [31:0]     a_i,
  input  logic [31:0]     b_i,
  input  logic [31:0]     hi_i,
  input  logic [31:0]     lo_i,
  output logic [63:0]     res_o
);

  logic [63:0] prod_s, prod_u, acc;
  logic [31:0] a_mag, b_mag, bs_safe, bu_safe;
  logic [31:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;

  assign acc    = {hi_i, lo_i};
  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed division is done on magnitudes. This keeps the divider unsigned,
  // and it gives truncation toward zero with the remainder taking the sign of a.
  assign a_mag   = a_i[31] ? -a_i : a_i;
  assign b_mag   = b_i[31] ? -b_i : b_i;
  assign bs_safe = (b_i == 32'd0) ? 32'd1 : b_mag;
  assign bu_safe = (b_i == 32'd0) ? 32'd1 : b_i;
  assign qs_mag  = a_mag / bs_safe;
  assign rs_mag  = a_mag % bs_safe;
  assign q_s     = (a_i[31] ^ b_i[31]) ? -qs_mag : qs_mag;
  assign r_s     = a_i[31] ? -rs_mag : rs_mag;
  assign q_u     = a_i / bu_safe;
  assign r_u     = a_i % bu_safe;

  always_comb begin
    res_o = acc;
    case (op_i)
      md_mult:  res_o = prod_s;
      md_multu: res_o = prod_u;
      md_div: begin
        if (b_i == 32'd0)
          res_o = {a_i, 32'hffff_ffff};
        else if (a_i == 32'h8000_0000 && b_i == 32'hffff_ffff)
          res_o = {32'd0, 32'h8000_0000};
        else
          res_o = {r_s, q_s};
      end
      md_divu: begin
        if (b_i == 32'd0)
          res_o = {a_i, 32'hffff_ffff};
        else
          res_o = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      md_madd:  res_o = acc + prod_s;
      md_maddu: res_o = acc + prod_u;
      md_msub:  res_o = acc - prod_s;
      md_msubu: res_o = acc - prod_u;
`endif
      default:  res_o = acc;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner and multi-cycle sequencer for the E-stage multiply/divide unit.
// Ports:
//   clk, reset      single clock; synchronous active-high reset
//   start, op       HI/LO operation valid in E, and its code
//   a, b            forwarded rs/rt values
//   exc_int         E-stage flush; it cancels an issue, not an operation in flight
//   busy            operation in flight
//   stall           busy, or a mult/div being issued this cycle
//   hi, lo          architectural HI/LO
//   done            one-cycle pulse when HI/LO take a mult/div result
// Optional feature macro: MDU_MADD_EN, which treats MADD/MADDU/MSUB/MSUBU as MULT_CYCLES ops.
//
// state   | meaning
// ST_IDLE | waiting for start; MTHI/MTLO write directly
// ST_MUL  | multiply (or MADD/MSUB) latency countdown
// ST_DIV  | divide latency countdown
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            exc_int,
  output logic            busy,
  output logic            stall,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            done
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_mul, is_div;
  logic [63:0]      result;

  mdu_arith u_arith (
    .op_i  (op),
    .a_i   (a),
    .b_i   (b),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (result)
  );

  always_comb begin
    is_mul = (op == md_mult) || (op == md_multu);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == md_madd) || (op == md_maddu) ||
             (op == md_msub) || (op == md_msubu);
`endif
    is_div = (op == md_div) || (op == md_divu);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !exc_int) begin
          if (is_mul) begin
            pend_d  = result;
            cnt_d   = MUL_LOAD;
            state_d = ST_MUL;
          end else if (is_div) begin
            pend_d  = result;
            cnt_d   = DIV_LOAD;
            state_d = ST_DIV;
          end else if (op == md_mthi) begin
            hi_d = a;
          end else if (op == md_mtlo) begin
            lo_d = a;
          end
        end
      end
      // A start seen here is a hazard-unit violation. It is ignored.
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = pend_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = busy | (start & (is_mul | is_div) & ~exc_int);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic            clk = 1'b0;
  logic            reset, start, exc_int;
  logic [OP_W-1:0] op;
  logic [31:0]     a, b;
  logic            busy, stall, done;
  logic [31:0]     hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .exc_int(exc_int), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit model_is_md(input logic [OP_W-1:0] o);
    bit r;
    r = (o == md_mult) || (o == md_multu) || (o == md_div) || (o == md_divu);
`ifdef MDU_MADD_EN
    r = r || (o == md_madd) || (o == md_maddu) || (o == md_msub) || (o == md_msubu);
`endif
    return r;
  endfunction

  function automatic int model_lat(input logic [OP_W-1:0] o);
    return ((o == md_div) || (o == md_divu)) ? ND : NM;
  endfunction

  function automatic logic [63:0] model_result(input logic [OP_W-1:0] o,
      input logic [31:0] x, y, h, l);
    longint sx, sy, q, rm;
    logic [63:0] acc, r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    acc = {h, l};
    r   = acc;
    case (o)
      md_mult:  r = 64'(sx * sy);
      md_multu: r = 64'(x) * 64'(y);
      md_div: begin
        if (y == 0) r = {x, 32'hffff_ffff};
        else if (x == 32'h8000_0000 && y == 32'hffff_ffff) r = {32'h0, 32'h8000_0000};
        else begin
          q  = sx / sy;
          rm = sx % sy;
          r  = {rm[31:0], q[31:0]};
        end
      end
      md_divu: r = (y == 0) ? {x, 32'hffff_ffff} : {x % y, x / y};
`ifdef MDU_MADD_EN
      md_madd:  r = acc + 64'(sx * sy);
      md_maddu: r = acc + 64'(x) * 64'(y);
      md_msub:  r = acc - 64'(sx * sy);
      md_msubu: r = acc - 64'(x) * 64'(y);
`endif
      default:  r = acc;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          m_busy = 0, m_done = 0;
  int          t_iss = 0, t_n = 0;

  // Timing model: an op accepted in cycle T is busy in T+1..T+N, and it commits at the end of cycle T+N.
  always @(posedge clk) begin
    if (reset) begin
      m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (m_busy) begin
        if (start) begin
          errors++;
          $display("FAIL protocol: start while busy at cycle %0d, got start=1 required 0", cyc);
        end
        if (cyc == t_iss + t_n) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1; m_busy <= 0;
        end
      end else if (start && !exc_int) begin
        if (model_is_md(op)) begin
          {p_hi, p_lo} <= model_result(op, a, b, m_hi, m_lo);
          m_busy <= 1;
          t_iss  <= cyc;
          t_n    <= model_lat(op);
        end else if (op == md_mthi) m_hi <= a;
        else if (op == md_mtlo) m_lo <= a;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (t=%0t): got %h required %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc hi", hi, m_hi);
      chk("cyc lo", lo, m_lo);
      chk("cyc stall", stall, m_busy | (start & model_is_md(op) & ~exc_int));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input logic [OP_W-1:0] o, input logic [31:0] aa, bb,
      input int exp_n, input int exc_at, input logic [31:0] ehi, elo, input string name);
    int bc;
    bit got;
    bc  = 0;
    got = 0;
    start = 1; op = o; a = aa; b = bb;
    #1;
    chk({name, " issue stall"}, stall, 1);
    tick();
    start = 0; a = 0; b = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      exc_int = (k == exc_at);
      if (done) got = 1;
      else begin
        bc += int'(busy);
        tick();
      end
    end
    exc_int = 0;
    chk({name, " done seen"}, got, 1);
    chk({name, " busy cycles"}, bc, exp_n);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
  endtask

  task automatic write_hl(input logic [OP_W-1:0] o, input logic [31:0] v);
    start = 1; op = o; a = v;
    #1;
    chk("mt stall", stall, 0);
    tick();
    start = 0; a = 0;
    chk("mt busy", busy, 0);
  endtask

  initial begin
    int dc;
    reset = 1; start = 0; exc_int = 0; op = '0; a = 0; b = 0;
    repeat (3) tick();
    reset = 0;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    // back-to-back: MULTU is issued in the done cycle of MULT
    run_md(md_mult,  32'hffff_ffff, 32'd2, NM, -1, 32'hffff_ffff, 32'hffff_fffe, "mult -1*2");
    run_md(md_multu, 32'hffff_ffff, 32'd2, NM, -1, 32'h0000_0001, 32'hffff_fffe, "multu");
    run_md(md_mult,  32'h8000_0000, 32'h8000_0000, NM, -1, 32'h4000_0000, 32'h0, "mult minmin");
    run_md(md_div,   32'hffff_fff9, 32'd2, ND, -1, 32'hffff_ffff, 32'hffff_fffd, "div -7/2");
    run_md(md_divu,  32'd7, 32'd0, ND, -1, 32'd7, 32'hffff_ffff, "divu by0");
    run_md(md_div,   32'hffff_fff9, 32'd0, ND, -1, 32'hffff_fff9, 32'hffff_ffff, "div by0");
    run_md(md_div,   32'h8000_0000, 32'hffff_ffff, ND, -1, 32'h0, 32'h8000_0000, "div ovf");

    write_hl(md_mthi, 32'h1234);
    chk("mthi hi", hi, 32'h1234);
    write_hl(md_mtlo, 32'd5);
    chk("mtlo lo", lo, 32'd5);
    chk("mtlo hi kept", hi, 32'h1234);

    // flushed issue is ignored
    start = 1; op = md_div; a = 100; b = 7; exc_int = 1;
    #1;
    chk("flush stall", stall, 0);
    tick();
    start = 0; exc_int = 0;
    chk("flush busy", busy, 0);
    tick();
    chk("flush busy2", busy, 0);
    chk("flush hi", hi, 32'h1234);
    chk("flush lo", lo, 32'd5);

    // a flush during flight does not cancel the operation
    run_md(md_div, 32'd100, 32'd7, ND, 3, 32'd2, 32'd14, "div exc mid");

    // reset at busy cycle 4 discards the operation
    start = 1; op = md_div; a = 50; b = 3;
    tick();
    start = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst mid hi", hi, 0);
    chk("rst mid lo", lo, 0);
    chk("rst mid busy", busy, 0);
    dc = 0;
    repeat (12) begin
      dc += int'(done);
      tick();
    end
    chk("rst mid no done", dc, 0);

    write_hl(md_mthi, 32'd0);
    write_hl(md_mtlo, 32'd5);
`ifdef MDU_MADD_EN
    run_md(md_madd,  32'd3, 32'd4, NM, -1, 32'd0, 32'd17, "madd");
    run_md(md_msubu, 32'd3, 32'd4, NM, -1, 32'd0, 32'd5, "msubu");
`else
    start = 1; op = md_madd; a = 3; b = 4;
    #1;
    chk("madd off stall", stall, 0);
    tick();
    start = 0;
    dc = 0;
    repeat (7) begin
      dc += int'(busy);
      tick();
    end
    chk("madd off busy", dc, 0);
    chk("madd off hi", hi, 0);
    chk("madd off lo", lo, 5);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
